// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder.
// Requester side uses the master modport, the adder uses the slave modport.
// When SERIAL_ADDER_SUB_EN is defined the bundle also carries the 'sub' select.
interface serial_adder_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
   logic             sub;
`endif
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

`ifdef SERIAL_ADDER_SUB_EN
   modport master (output start, output a, output b, output cin, output sub,
                   input busy, input done, input sum, input cout);
   modport slave  (input start, input a, input b, input cin, input sub,
                   output busy, output done, output sum, output cout);
`else
   modport master (output start, output a, output b, output cin,
                   input busy, input done, input sum, input cout);
   modport slave  (input start, input a, input b, input cin,
                   output busy, output done, output sum, output cout);
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder bit per clock, LSB first, with the
// carry held in a flip-flop between cycles. {cout,sum} = a + b + cin.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds a 'sub' select that latches
// ~b with an initial carry of 1, giving a - b (cout=1 means no borrow).
// Reset is synchronous and active-low.
module serial_adder #(
   parameter int WIDTH = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   serial_adder_if.slave  bus
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q,  state_d;
   logic [WIDTH-1:0] a_sh_q,   a_sh_d;
   logic [WIDTH-1:0] b_sh_q,   b_sh_d;
   logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
   logic [WIDTH-1:0] sum_q,    sum_d;
   logic             carry_q,  carry_d;
   logic             cout_q,   cout_d;
   logic [CW-1:0]    cnt_q,    cnt_d;

   logic             s_bit_s;
   logic             c_bit_s;
   logic             load_s;
   logic [WIDTH-1:0] b_load_s;
   logic             carry_load_s;

   // Majority of three bits: the carry out of a one-bit full adder.
   function automatic logic maj3(input logic x, input logic y, input logic z);
      return (x & y) | (x & z) | (y & z);
   endfunction

   // Operand capture values, including the optional subtract transform.
   always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
      b_load_s     = bus.sub ? ~bus.b : bus.b;
      carry_load_s = bus.sub ? 1'b1 : bus.cin;
`else
      b_load_s     = bus.b;
      carry_load_s = bus.cin;
`endif
   end

   // Next-state logic: sequencing, serial full-adder step and result capture.
   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      sum_sh_d = sum_sh_q;
      sum_d    = sum_q;
      carry_d  = carry_q;
      cout_d   = cout_q;
      cnt_d    = cnt_q;
      load_s   = 1'b0;
      s_bit_s  = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
      c_bit_s  = maj3(a_sh_q[0], b_sh_q[0], carry_q);

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               load_s  = 1'b1;
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            // start is deliberately ignored here
            carry_d  = c_bit_s;
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            sum_sh_d = sum_sh_q >> 1;
            sum_sh_d[WIDTH-1] = s_bit_s;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               // result registers only ever see a complete sum
               sum_d   = sum_sh_d;
               cout_d  = c_bit_s;
               state_d = S_DONE;
            end else begin
               state_d = S_RUN;
            end
         end
         S_DONE: begin
            if (bus.start) begin
               load_s  = 1'b1;
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (load_s) begin
         a_sh_d   = bus.a;
         b_sh_d   = b_load_s;
         carry_d  = carry_load_s;
         cnt_d    = '0;
         sum_sh_d = '0;
      end else begin
         cnt_d    = cnt_d;
      end
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         sum_sh_q <= '0;
         sum_q    <= '0;
         carry_q  <= 1'b0;
         cout_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         sum_sh_q <= sum_sh_d;
         sum_q    <= sum_d;
         carry_q  <= carry_d;
         cout_q   <= cout_d;
         cnt_q    <= cnt_d;
      end
   end

   // Status flags are decoded straight from the state register.
   assign bus.busy = (state_q == S_RUN);
   assign bus.done = (state_q == S_DONE);
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;

endmodule
